// File: rtl/datapath_unit.sv
// Execution datapath: Reg A/B, ADD/SUB with flags, small data memory with a
// registered debug read port, store event reporting and a sticky illegal flag.
module datapath_unit #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              alu_op,
    input  logic              do_alu,
    input  logic              do_store,
    input  logic [3:0]        mem_rd_addr,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              store_valid,
    output logic [3:0]        store_addr,
    output logic [DATA_W-1:0] store_data,
    output logic [CNT_W-1:0]  store_count,
    output logic              illegal_op
);

    logic [DATA_W-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic              zero_q, zero_d, carry_q, carry_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] mem_d [MEM_DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              store_valid_q, store_valid_d;
    logic [3:0]        store_addr_q, store_addr_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [CNT_W-1:0]  store_count_q, store_count_d;
    logic              illegal_q, illegal_d;

    logic              st_ok, rd_ok;
    logic [DATA_W:0]   sum, diff, res;

    // A 4-bit address can only fall outside the memory when it is shallower than 16.
    if (MEM_DEPTH >= 16) begin : g_full_map
        assign st_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part_map
        assign st_ok = int'({28'd0, instr[3:0]}) < MEM_DEPTH;
        assign rd_ok = int'({28'd0, mem_rd_addr}) < MEM_DEPTH;
    end

    // Borrow falls out as the extra top bit of the widened subtraction.
    assign sum  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
    assign diff = {1'b0, reg_a_q} - {1'b0, reg_b_q};
    assign res  = alu_op ? diff : sum;

    always_comb begin
        reg_a_d       = reg_a_q;
        reg_b_d       = reg_b_q;
        alu_result_d  = alu_result_q;
        zero_d        = zero_q;
        carry_d       = carry_q;
        mem_d         = mem_q;
        store_valid_d = 1'b0;
        store_addr_d  = store_addr_q;
        store_data_d  = store_data_q;
        store_count_d = store_count_q;
        illegal_d     = illegal_q | ($countones({we_a, we_b, do_alu, do_store}) > 1);
        rd_data_d     = rd_ok ? mem_q[mem_rd_addr] : '0;

        if (do_store) begin
            store_valid_d = 1'b1;
            store_addr_d  = instr[3:0];
            store_data_d  = reg_a_q;
            if (store_count_q != '1)
                store_count_d = store_count_q + CNT_W'(1);
            if (st_ok)
                mem_d[instr[3:0]] = reg_a_q;
            else
                illegal_d = 1'b1;
        end else if (do_alu) begin
            reg_a_d      = res[DATA_W-1:0];
            alu_result_d = res[DATA_W-1:0];
            carry_d      = res[DATA_W];
            zero_d       = (res[DATA_W-1:0] == '0);
        end else if (we_a) begin
            reg_a_d = DATA_W'(instr[3:0]);
        end else if (we_b) begin
            reg_b_d = DATA_W'(instr[3:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a_q       <= '0;
            reg_b_q       <= '0;
            alu_result_q  <= '0;
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            rd_data_q     <= '0;
            store_valid_q <= 1'b0;
            store_addr_q  <= '0;
            store_data_q  <= '0;
            store_count_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            reg_a_q       <= reg_a_d;
            reg_b_q       <= reg_b_d;
            alu_result_q  <= alu_result_d;
            zero_q        <= zero_d;
            carry_q       <= carry_d;
            mem_q         <= mem_d;
            rd_data_q     <= rd_data_d;
            store_valid_q <= store_valid_d;
            store_addr_q  <= store_addr_d;
            store_data_q  <= store_data_d;
            store_count_q <= store_count_d;
            illegal_q     <= illegal_d;
        end
    end

    assign reg_a       = reg_a_q;
    assign reg_b       = reg_b_q;
    assign alu_result  = alu_result_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign mem_rd_data = rd_data_q;
    assign store_valid = store_valid_q;
    assign store_addr  = store_addr_q;
    assign store_data  = store_data_q;
    assign store_count = store_count_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: an integer-arithmetic model checked every
// cycle, plus literal expectations taken from worked examples.
module tb_datapath_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = '0;
    logic       we_a = 1'b0, we_b = 1'b0, alu_op = 1'b0, do_alu = 1'b0, do_store = 1'b0;
    logic [3:0] mem_rd_addr = '0;
    logic [7:0] reg_a, reg_b, alu_result, mem_rd_data, store_data, store_count;
    logic       zero_flag, carry_flag, store_valid, illegal_op;
    logic [3:0] store_addr;

    datapath_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .we_a(we_a), .we_b(we_b),
        .alu_op(alu_op), .do_alu(do_alu), .do_store(do_store),
        .mem_rd_addr(mem_rd_addr), .reg_a(reg_a), .reg_b(reg_b),
        .alu_result(alu_result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .mem_rd_data(mem_rd_data), .store_valid(store_valid), .store_addr(store_addr),
        .store_data(store_data), .store_count(store_count), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: plain integers, the rules applied directly.
    int m_a, m_b, m_alu, m_rd, m_sa, m_sd, m_cnt;
    bit m_z, m_c, m_sv, m_ill;
    int m_mem [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = 0; m_b = 0; m_alu = 0; m_rd = 0; m_sa = 0; m_sd = 0; m_cnt = 0;
            m_z = 0; m_c = 0; m_sv = 0; m_ill = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 0;
        end else begin
            int n, r, ad;
            m_rd = m_mem[mem_rd_addr];
            n = int'(we_a) + int'(we_b) + int'(do_alu) + int'(do_store);
            if (n > 1) m_ill = 1;
            m_sv = 0;
            ad = int'(instr[3:0]);
            if (do_store) begin
                m_sv = 1; m_sa = ad; m_sd = m_a;
                m_mem[ad] = m_a;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end else if (do_alu) begin
                if (!alu_op) begin
                    r = m_a + m_b;
                    m_c = (r > 255);
                    r = r % 256;
                end else begin
                    m_c = (m_a < m_b);
                    r = (m_a - m_b + 256) % 256;
                end
                m_a = r; m_alu = r; m_z = (r == 0);
            end else if (we_a) begin
                m_a = ad;
            end else if (we_b) begin
                m_b = ad;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("reg_a", 32'(reg_a), 32'(m_a));
            chk("reg_b", 32'(reg_b), 32'(m_b));
            chk("alu_result", 32'(alu_result), 32'(m_alu));
            chk("zero_flag", 32'(zero_flag), 32'(m_z));
            chk("carry_flag", 32'(carry_flag), 32'(m_c));
            chk("mem_rd_data", 32'(mem_rd_data), 32'(m_rd));
            chk("store_valid", 32'(store_valid), 32'(m_sv));
            chk("store_addr", 32'(store_addr), 32'(m_sa));
            chk("store_data", 32'(store_data), 32'(m_sd));
            chk("store_count", 32'(store_count), 32'(m_cnt));
            chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        end
    end

    // Present one cycle of strobes, return just after the sampling edge.
    task automatic step(input logic [7:0] ins, input bit s, input bit al, input bit op,
                        input bit a, input bit b);
        instr = ins; do_store = s; do_alu = al; alu_op = op; we_a = a; we_b = b;
        @(posedge clk); #1;
        do_store = 0; do_alu = 0; alu_op = 0; we_a = 0; we_b = 0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic load_a(input logic [7:0] v); step(v, 0, 0, 0, 1, 0); endtask
    task automatic load_b(input logic [7:0] v); step(v, 0, 0, 0, 0, 1); endtask
    task automatic alu(input bit op);           step(8'h00, 0, 1, op, 0, 0); endtask
    task automatic store(input logic [7:0] v);  step(v, 1, 0, 0, 0, 0); endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        chk("rst reg_a", 32'(reg_a), 0);
        chk("rst store_count", 32'(store_count), 0);
        rst = 0;
        idle();

        // LOAD/ADD
        load_a(8'h13); load_b(8'h25); alu(0);
        chk("add reg_a", 32'(reg_a), 8);
        chk("add alu_result", 32'(alu_result), 8);
        chk("add zero", 32'(zero_flag), 0);
        chk("add carry", 32'(carry_flag), 0);

        // SUB with borrow, then SUB to zero
        load_a(8'h02); load_b(8'h05); alu(1);
        chk("sub reg_a", 32'(reg_a), 32'hFD);
        chk("sub carry", 32'(carry_flag), 1);
        chk("sub zero", 32'(zero_flag), 0);
        load_a(8'h05); alu(1);
        chk("sub0 reg_a", 32'(reg_a), 0);
        chk("sub0 zero", 32'(zero_flag), 1);
        chk("sub0 carry", 32'(carry_flag), 0);

        // 15 + 16*15 = 255, then +1 overflows
        load_a(8'h0F); load_b(8'h0F);
        repeat (16) alu(0);
        chk("preset reg_a", 32'(reg_a), 32'hFF);
        load_b(8'h01); alu(0);
        chk("ovf reg_a", 32'(reg_a), 0);
        chk("ovf carry", 32'(carry_flag), 1);
        chk("ovf zero", 32'(zero_flag), 1);

        // Store, reading the same address in the store cycle
        load_a(8'h0A);
        mem_rd_addr = 4'd7;
        store(8'h67);
        chk("st valid", 32'(store_valid), 1);
        chk("st addr", 32'(store_addr), 7);
        chk("st data", 32'(store_data), 32'h0A);
        chk("st count", 32'(store_count), 1);
        chk("st rd old", 32'(mem_rd_data), 0);
        idle();
        chk("st valid drop", 32'(store_valid), 0);
        chk("st rd new", 32'(mem_rd_data), 32'h0A);

        // Conflict: we_a + do_alu, ALU wins (0x0A + 1)
        step(8'h03, 0, 1, 0, 1, 0);
        chk("conf reg_a", 32'(reg_a), 32'h0B);
        chk("conf illegal", 32'(illegal_op), 1);
        idle(); idle();
        chk("illegal sticky", 32'(illegal_op), 1);

        // Saturation with a mix of loads and back-to-back stores
        for (int i = 0; i < 300; i++) begin
            if (i % 4 == 0) load_a(8'(i));
            mem_rd_addr = 4'(i * 7);
            store(8'(i));
        end
        chk("sat count", 32'(store_count), 255);
        store(8'h01);
        chk("sat hold", 32'(store_count), 255);

        // Reset mid-run with a store pending
        instr = 8'h62; do_store = 1;
        #2 rst = 1;
        @(posedge clk); #1;
        do_store = 0;
        chk("mrst reg_a", 32'(reg_a), 0);
        chk("mrst store_count", 32'(store_count), 0);
        chk("mrst illegal", 32'(illegal_op), 0);
        chk("mrst store_valid", 32'(store_valid), 0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            mem_rd_addr = 4'(i);
            idle();
            chk("mrst mem", 32'(mem_rd_data), 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath directly downstream of the control FSM.
- Consumes the FSM's one-cycle strobes (we_a, we_b, do_alu, alu_op, do_store) together with the instruction byte held during EXECUTE.
- Holds Reg A and Reg B, performs ADD/SUB into Reg A with flags, and stores Reg A into an internal data memory addressed by the instruction's low nibble.
- Provides a registered debug read port, a store event pulse and a sticky illegal-strobe flag.

Parameters:
- DATA_W, 8, width of Reg A, Reg B, ALU and data-memory words.
- MEM_DEPTH, 16, number of data-memory words; addressed by instr[3:0]; must be ≤ 16.
- CNT_W, 8, width of the saturating store counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  8  current instruction; instr[3:0] is the immediate or store address.
- we_a  in  1  load immediate into Reg A.
- we_b  in  1  load immediate into Reg B.
- alu_op  in  1  0 = ADD, 1 = SUB; sampled only when do_alu = 1.
- do_alu  in  1  execute ALU op, result into Reg A.
- do_store  in  1  write Reg A to mem[instr[3:0]].
- mem_rd_addr  in  4  debug read address.
- reg_a  out  DATA_W  Reg A contents.
- reg_b  out  DATA_W  Reg B contents.
- alu_result  out  DATA_W  last ALU result, registered.
- zero_flag  out  1  last ALU result == 0.
- carry_flag  out  1  ADD carry-out / SUB borrow.
- mem_rd_data  out  DATA_W  mem[mem_rd_addr], 1-cycle latency.
- store_valid  out  1  one-cycle pulse after a store.
- store_addr  out  4  address of the last store.
- store_data  out  DATA_W  data of the last store.
- store_count  out  CNT_W  number of stores, saturating.
- illegal_op  out  1  sticky; more than one strobe was asserted in the same cycle.

Behaviour:
- Reset (async, rst = 1): every output and register goes to 0, including all MEM_DEPTH memory words, illegal_op and store_count. Release is synchronous to the next clk edge. Reset mid-operation discards any strobe present in that cycle.
- Strobes are sampled on the rising edge; instr must be stable in the same cycle. Effects are visible on outputs the cycle after the strobe edge.
- we_a: reg_a <= {zero-extend instr[3:0]}. Flags are unchanged.
- we_b: reg_b <= {zero-extend instr[3:0]}. Flags are unchanged.
- do_alu, alu_op = 0: sum = reg_a + reg_b at DATA_W+1 bits.
  - reg_a and alu_result <= sum[DATA_W-1:0].
  - carry_flag <= sum[DATA_W].
- do_alu, alu_op = 1: reg_a and alu_result <= (reg_a − reg_b) mod 2^DATA_W.
  - carry_flag <= (reg_a < reg_b), i.e. borrow.
- zero_flag <= (new result == 0) on every do_alu. Flags hold otherwise.
- do_store: mem[instr[3:0]] <= reg_a (the pre-edge value). On the next cycle:
  - store_valid = 1 for exactly one cycle.
  - store_addr = instr[3:0].
  - store_data = stored value.
  - store_count increments and saturates at 2^CNT_W − 1 (no wrap).
- Addresses ≥ MEM_DEPTH: the store is dropped, store_valid still pulses, illegal_op is set.
- Multiple strobes in one cycle: only the highest-priority strobe acts (do_store > do_alu > we_a > we_b), and illegal_op <= 1. illegal_op clears only on reset.
- Debug read: mem_rd_data <= mem[mem_rd_addr] every cycle.
  - A read of the address being stored in the same cycle returns the old data; the new data appears one cycle later.
  - Read addresses ≥ MEM_DEPTH return 0.
- No strobe asserted: all state holds and store_valid = 0.
- Back-to-back strobes on consecutive cycles are legal; each uses the register values updated by the previous edge.

Test Plan:
- Reset: drive rst = 1 mid-run after stores → all outputs 0, store_count = 0, mem_rd_data = 0 for every address after release.
- LOAD/ADD: we_a with instr = 8'h13, then we_b with instr = 8'h25, then do_alu with alu_op = 0 → reg_a = 8, alu_result = 8, zero = 0, carry = 0.
- SUB borrow: reg_a = 2, reg_b = 5, do_alu with alu_op = 1 → reg_a = 8'hFD, carry = 1, zero = 0. Then reg_a = 5, reg_b = 5, SUB → reg_a = 0, zero = 1, carry = 0.
- ADD overflow: reg_a = 8'hFF (preset by repeated ADDs), reg_b = 1, ADD → reg_a = 0, carry = 1, zero = 1.
- Store: reg_a = 8'h0A, do_store with instr = 8'h67 → next cycle store_valid = 1, store_addr = 7, store_data = 8'h0A, store_count = 1. mem_rd_addr = 7 → mem_rd_data = 8'h0A one cycle later.
- Conflict and saturation: we_a and do_alu together → only the ALU op executes and illegal_op = 1 (sticky). 300 stores → store_count = 255.
